// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared definitions for the instruction-memory program loader.
//   state_e    - loader FSM states
//   WORD_BYTES - bytes per memory word
//   lane_lsb() - bit offset of byte lane idx within a 32-bit word
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    VERIFY,
    DONE,
    FAIL
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/inst_loader_packer.sv
// inst_loader_packer: assembles four stream bytes little-endian into one word.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   clr_i          - restart packing (accepted load request)
//   beat_i         - a byte is transferred this cycle
//   byte_i         - the transferred byte
//   word_o         - registered word (complete after the 4th beat)
//   word_next_o    - word including the byte of the current beat
//   word_done_o    - current beat completes the word
module inst_loader_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        beat_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [31:0] word_next_o,
  output logic        word_done_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  always_comb begin
    word_next_o = word_q;
    word_next_o[lane_lsb(idx_q) +: 8] = byte_i;
  end

  assign word_done_o = beat_i && (idx_q == 2'd3);
  assign word_o      = word_q;

  // idx wraps 3 -> 0, so the next word starts at lane 0 without extra logic.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (beat_i) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= word_next_o;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: loads a byte stream into instruction memory word by word,
// reading back and comparing each word after it is written.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   start, word_count     - load request and number of words
//   byte_valid/byte_data  - byte source; byte_ready accepts a byte
//   mem_addr/mem_din/mem_we - memory write port; mem_dout combinational read
//   busy, done, error     - status (error is sticky until next start)
//   err_addr              - byte address of the failing word
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] err_addr
);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;
  logic [31:0] err_addr_q;
  logic        byte_ready_q;
  logic        mem_we_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  logic        start_acc;
  logic        beat;
  logic        word_done;
  logic [31:0] word;
  logic [31:0] word_next;
  logic [32:0] last_byte;
  logic        addr_over;

  assign start_acc = (state_q == IDLE) && start;
  // byte_ready_q is high only in COLLECT, so a beat can only occur there.
  assign beat      = byte_valid && byte_ready_q;

  // 33-bit sum so an address near 2^32 cannot wrap past the bound check.
  assign last_byte = {1'b0, mem_addr_q} + 33'(WORD_BYTES - 1);
  assign addr_over = last_byte > 33'(MEM_BYTES - 1);

  inst_loader_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start_acc),
    .beat_i      (beat),
    .byte_i      (byte_data),
    .word_o      (word),
    .word_next_o (word_next),
    .word_done_o (word_done)
  );

  // mem_addr_q doubles as the address counter: it is loaded on entry to
  // COLLECT, so it is already stable the cycle before mem_we rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      mem_addr_q   <= 32'd0;
      mem_din_q    <= 32'd0;
      err_addr_q   <= 32'd0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            if (word_count == 16'd0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q        <= word_count;
              mem_addr_q   <= BASE_ADDR;
              byte_ready_q <= 1'b1;
              state_q      <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (word_done) begin
            byte_ready_q <= 1'b0;
            if (addr_over) begin
              err_addr_q <= mem_addr_q;
              error_q    <= 1'b1;
              state_q    <= FAIL;
            end else begin
              mem_din_q <= word_next;
              mem_we_q  <= 1'b1;
              state_q   <= WRITE;
            end
          end
        end
        WRITE: begin
          state_q <= VERIFY;
        end
        VERIFY: begin
          if (mem_dout != word) begin
            err_addr_q <= mem_addr_q;
            error_q    <= 1'b1;
            state_q    <= FAIL;
          end else if (cnt_q == 16'd1) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q        <= cnt_q - 16'd1;
            mem_addr_q   <= mem_addr_q + 32'(WORD_BYTES);
            byte_ready_q <= 1'b1;
            state_q      <= COLLECT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        FAIL: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: two instances (BASE_ADDR 0 and 1020) each attached
// to a small memory model with an injectable read corruption.
module tb_inst_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [2];
  logic [15:0] wc_v    [2];
  logic        bv_v    [2];
  logic [7:0]  bd_v    [2];
  logic        br_v    [2];
  logic [31:0] maddr_v [2];
  logic [31:0] mdin_v  [2];
  logic        mwe_v   [2];
  logic [31:0] mdout_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        err_v   [2];
  logic [31:0] eaddr_v [2];
  logic        bad_v   [2];

  logic [31:0] mem [2][256];

  assign mdout_v[0] = bad_v[0] ? 32'hDEADBEEF : mem[0][maddr_v[0][9:2]];
  assign mdout_v[1] = bad_v[1] ? 32'hDEADBEEF : mem[1][maddr_v[1][9:2]];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      if (mwe_v[u]) mem[u][maddr_v[u][9:2]] <= mdin_v[u];
  end

  inst_loader #(.BASE_ADDR(32'd0), .MEM_BYTES(1024)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .word_count(wc_v[0]),
    .byte_valid(bv_v[0]), .byte_data(bd_v[0]), .byte_ready(br_v[0]),
    .mem_addr(maddr_v[0]), .mem_din(mdin_v[0]), .mem_we(mwe_v[0]),
    .mem_dout(mdout_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .error(err_v[0]), .err_addr(eaddr_v[0])
  );

  inst_loader #(.BASE_ADDR(32'd1020), .MEM_BYTES(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .word_count(wc_v[1]),
    .byte_valid(bv_v[1]), .byte_data(bd_v[1]), .byte_ready(br_v[1]),
    .mem_addr(maddr_v[1]), .mem_din(mdin_v[1]), .mem_we(mwe_v[1]),
    .mem_dout(mdout_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .error(err_v[1]), .err_addr(eaddr_v[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write log and write-port timing monitor.
  logic [63:0] wlog0[$];
  logic [63:0] wlog1[$];
  logic [31:0] prev_addr [2];
  logic [31:0] prev_din  [2];
  logic        prev_we   [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_n) begin
        if (prev_we[u] === 1'b1) begin
          check("we_single_cycle", 64'(mwe_v[u]), 64'd0);
          check("addr_held_verify", 64'(maddr_v[u]), 64'(prev_addr[u]));
          check("din_held_verify", 64'(mdin_v[u]), 64'(prev_din[u]));
        end else if (mwe_v[u] === 1'b1) begin
          check("addr_setup_before_we", 64'(maddr_v[u]), 64'(prev_addr[u]));
        end
      end
      if (mwe_v[u] === 1'b1) begin
        if (u == 0) wlog0.push_back({maddr_v[u], mdin_v[u]});
        else        wlog1.push_back({maddr_v[u], mdin_v[u]});
      end
      prev_addr[u] <= maddr_v[u];
      prev_din[u]  <= mdin_v[u];
      prev_we[u]   <= mwe_v[u];
    end
  end

  // Reference: word k is bytes 4k..4k+3, little-endian.
  function automatic logic [31:0] model_word(input logic [7:0] b[$], input int k);
    return {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
  endfunction

  // Drives one load. Cycle 0 is the cycle start is high; observations are
  // taken on each following falling edge. mode: 0 back-to-back, 1 valid every
  // other cycle, 2 random valid. A refused byte is held until accepted.
  task automatic run_load(input int u, input logic [7:0] bytes[$], input logic [15:0] wc,
                          input int mode, input int abort, input bit corrupt, input bit poke,
                          output int done_cyc, output int we_cnt, output int rdy_cnt,
                          output bit err_seen);
    int bi;
    int cyc;
    bit acc;
    bi = 0; cyc = 0; acc = 1'b0;
    done_cyc = -1; we_cnt = 0; rdy_cnt = 0; err_seen = 1'b0;
    @(negedge clk);
    if (u == 0) wlog0.delete(); else wlog1.delete();
    start_v[u] = 1'b1;
    wc_v[u]    = wc;
    bv_v[u]    = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start_v[u] = 1'b0;
      if (acc) bi++;
      if (abort > 0 && bi == abort) begin
        bv_v[u] = 1'b0;
        break;
      end
      if (mwe_v[u]) begin
        we_cnt++;
        if (corrupt && we_cnt == 1) bad_v[u] = 1'b1;
      end
      if (br_v[u]) rdy_cnt++;
      if (done_v[u] && done_cyc < 0) done_cyc = cyc;
      if (err_v[u]) err_seen = 1'b1;
      if (done_cyc >= 0 || err_seen) begin
        bv_v[u] = 1'b0;
        break;
      end
      if (poke && cyc == 3) begin
        start_v[u] = 1'b1;
        wc_v[u]    = 16'd1;
      end
      if (!(bv_v[u] && !acc)) begin
        if (bi < bytes.size()) begin
          case (mode)
            0:       bv_v[u] = 1'b1;
            1:       bv_v[u] = (cyc % 2) == 1;
            default: bv_v[u] = 1'($urandom_range(0, 1));
          endcase
          bd_v[u] = bytes[bi];
        end else begin
          bv_v[u] = 1'b0;
        end
      end
      acc = bv_v[u] && br_v[u];
    end
    bad_v[u] = 1'b0;
  endtask

  task automatic check_words(input int u, input logic [7:0] bytes[$], input int n,
                             input logic [31:0] base);
    logic [63:0] got;
    logic [31:0] ea;
    int sz;
    sz = (u == 0) ? wlog0.size() : wlog1.size();
    check("write_count", 64'(sz), 64'(n));
    for (int k = 0; k < n; k++) begin
      ea  = base + 32'(4 * k);
      got = 64'hxxxx_xxxx_xxxx_xxxx;
      if (k < sz) got = (u == 0) ? wlog0[k] : wlog1[k];
      check($sformatf("wr_addr%0d", k), 64'(got[63:32]), 64'(ea));
      check($sformatf("wr_data%0d", k), 64'(got[31:0]), 64'(model_word(bytes, k)));
      check($sformatf("mem_word%0d", k), 64'(mem[u][ea[9:2]]), 64'(model_word(bytes, k)));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] qe[$];
    int dc, wcnt, rc, wcr, md;
    bit es;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0; wc_v[u] = 16'd0; bv_v[u] = 1'b0; bd_v[u] = 8'd0; bad_v[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_byte_ready", 64'(br_v[0]), 64'd0);
    check("rst_mem_addr", 64'(maddr_v[0]), 64'd0);
    check("rst_mem_din", 64'(mdin_v[0]), 64'd0);
    check("rst_mem_we", 64'(mwe_v[0]), 64'd0);
    check("rst_busy", 64'(busy_v[0]), 64'd0);
    check("rst_done", 64'(done_v[0]), 64'd0);
    check("rst_error", 64'(err_v[0]), 64'd0);
    check("rst_err_addr", 64'(eaddr_v[0]), 64'd0);
    check("rst_mem_addr_b", 64'(maddr_v[1]), 64'd0);
    rst_n = 1'b1;

    // Back-to-back two-word program.
    q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
    run_load(0, q, 16'd2, 0, 0, 1'b0, 1'b0, dc, wcnt, rc, es);
    check("t1_done_cycle", 64'(dc), 64'd13);
    check("t1_we_cycles", 64'(wcnt), 64'd2);
    check("t1_error", 64'(es), 64'd0);
    check("t1_word0", 64'(mem[0][0]), 64'h0050_0013);
    check("t1_word1", 64'(mem[0][1]), 64'h0020_80B3);
    check_words(0, q, 2, 32'd0);
    @(negedge clk);
    check("t1_busy_after", 64'(busy_v[0]), 64'd0);
    check("t1_done_one_cycle", 64'(done_v[0]), 64'd0);

    // Same program, valid every other cycle.
    run_load(0, q, 16'd2, 1, 0, 1'b0, 1'b0, dc, wcnt, rc, es);
    check("t2_done_seen", 64'(dc > 0), 64'd1);
    check("t2_we_cycles", 64'(wcnt), 64'd2);
    check_words(0, q, 2, 32'd0);

    // Bound check: second word starts at byte 1024 of a 1024-byte memory.
    run_load(1, q, 16'd2, 0, 0, 1'b0, 1'b0, dc, wcnt, rc, es);
    check("t3_error", 64'(es), 64'd1);
    check("t3_err_addr", 64'(eaddr_v[1]), 64'd1024);
    check("t3_we_cycles", 64'(wcnt), 64'd1);
    check("t3_no_done", 64'(dc), -64'sd1);
    check_words(1, q, 1, 32'd1020);
    repeat (3) @(negedge clk);
    check("t3_error_sticky", 64'(err_v[1]), 64'd1);
    check("t3_busy_after", 64'(busy_v[1]), 64'd0);
    check("t3_no_late_we", 64'(wlog1.size()), 64'd1);

    // Corrupted read-back of word 0.
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    run_load(0, q, 16'd2, 0, 0, 1'b1, 1'b0, dc, wcnt, rc, es);
    check("t4_error", 64'(es), 64'd1);
    check("t4_err_addr", 64'(eaddr_v[0]), 64'd0);
    check("t4_no_done", 64'(dc), -64'sd1);
    check("t4_we_cycles", 64'(wcnt), 64'd1);
    repeat (3) @(negedge clk);
    check("t4_error_sticky", 64'(err_v[0]), 64'd1);
    check("t4_busy_after", 64'(busy_v[0]), 64'd0);

    // Zero-length load; also clears the sticky error.
    qe.delete();
    run_load(0, qe, 16'd0, 0, 0, 1'b0, 1'b0, dc, wcnt, rc, es);
    check("t5_done_cycle", 64'(dc), 64'd1);
    check("t5_we_cycles", 64'(wcnt), 64'd0);
    check("t5_ready_cycles", 64'(rc), 64'd0);
    check("t5_error_cleared", 64'(err_v[0]), 64'd0);

    // Reset after two bytes of word 1, then a fresh load.
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    run_load(0, q, 16'd2, 0, 6, 1'b0, 1'b0, dc, wcnt, rc, es);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_ready", 64'(br_v[0]), 64'd0);
    check("t6_rst_busy", 64'(busy_v[0]), 64'd0);
    check("t6_rst_we", 64'(mwe_v[0]), 64'd0);
    check("t6_word0_kept", 64'(mem[0][0]), 64'(model_word(q, 0)));
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    run_load(0, q, 16'd3, 2, 0, 1'b0, 1'b0, dc, wcnt, rc, es);
    check("t6_done_seen", 64'(dc > 0), 64'd1);
    check_words(0, q, 3, 32'd0);

    // Randomized loads with a start pulse while busy.
    for (int it = 0; it < 4; it++) begin
      wcr = $urandom_range(1, 5);
      md  = it % 3;
      q.delete();
      for (int i = 0; i < 4 * wcr; i++) q.push_back(8'($urandom));
      run_load(0, q, 16'(wcr), md, 0, 1'b0, 1'b1, dc, wcnt, rc, es);
      check($sformatf("r%0d_done_seen", it), 64'(dc > 0), 64'd1);
      check($sformatf("r%0d_error", it), 64'(es), 64'd0);
      check($sformatf("r%0d_we_cycles", it), 64'(wcnt), 64'(wcr));
      if (md == 0) check($sformatf("r%0d_done_cycle", it), 64'(dc), 64'(6 * wcr + 1));
      check_words(0, q, wcr, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
